// File: rtl/seg7_scan_if.sv
// BCD capture bus into the 3-digit scanner: load strobe plus hundreds/tens/units digits.
interface seg7_scan_if;
  logic       load;
  logic [3:0] centena;
  logic [3:0] dezena;
  logic [3:0] unidade;

  modport master (output load, centena, dezena, unidade);
  modport slave  (input  load, centena, dezena, unidade);
endinterface

// File: rtl/seg7_scan.sv
// Three-digit multiplexed 7-segment scanner with frame-synchronous commit of BCD digits.
// Optional leading-zero blanking is compiled in with SEG7_BLANK_LZ_EN.
//
// state    | meaning
// SCAN_UNI | units digit enabled
// SCAN_DEZ | tens digit enabled
// SCAN_CEN | hundreds digit enabled; tick here is the frame boundary
// SCAN_BAD | illegal, returns to SCAN_UNI next clock
module seg7_scan #(
  parameter int DIV_WIDTH      = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  seg7_scan_if.slave       bcd,
  output logic [6:0]       seg,
  output logic [2:0]       an,
  output logic             frame,
  output logic             err
);

  typedef enum logic [1:0] {
    SCAN_UNI = 2'd0,
    SCAN_DEZ = 2'd1,
    SCAN_CEN = 2'd2,
    SCAN_BAD = 2'd3
  } scan_e;

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [2:0] AN_OFF  = AN_ACTIVE_LOW  ? 3'h7  : 3'h0;

  logic [DIV_WIDTH-1:0] div_q, div_d;
  scan_e                idx_q, idx_d;
  logic [3:0]           pcen_q, pcen_d, pdez_q, pdez_d, puni_q, puni_d;
  logic                 pvld_q, pvld_d;
  logic [3:0]           cen_q, cen_d, dez_q, dez_d, uni_q, uni_d;
  logic                 err_q, err_d;
  logic [6:0]           seg_q, seg_d;
  logic [2:0]           an_q, an_d;
  logic                 tick;
  logic                 frame_b;
  logic [3:0]           cur_dig;
  logic                 blank;
  logic [6:0]           lit;
  logic [2:0]           an_oh;

  // seg[0]=a .. seg[6]=g, active-high "lit" before polarity
  function automatic logic [6:0] dec7(input logic [3:0] v);
    case (v)
      4'd0:    dec7 = 7'b0111111;
      4'd1:    dec7 = 7'b0000110;
      4'd2:    dec7 = 7'b1011011;
      4'd3:    dec7 = 7'b1001111;
      4'd4:    dec7 = 7'b1100110;
      4'd5:    dec7 = 7'b1101101;
      4'd6:    dec7 = 7'b1111101;
      4'd7:    dec7 = 7'b0000111;
      4'd8:    dec7 = 7'b1111111;
      4'd9:    dec7 = 7'b1101111;
      default: dec7 = 7'b1000000;
    endcase
  endfunction

  always_comb begin
    div_d   = div_q + DIV_ONE;
    tick    = &div_q;
    idx_d   = idx_q;
    frame_b = 1'b0;
    case (idx_q)
      SCAN_UNI: if (tick) idx_d = SCAN_DEZ;
      SCAN_DEZ: if (tick) idx_d = SCAN_CEN;
      SCAN_CEN: begin
        frame_b = tick;
        if (tick) idx_d = SCAN_UNI;
      end
      default:  idx_d = SCAN_UNI;
    endcase
  end

  // A load coinciding with the frame boundary bypasses the pending set entirely.
  always_comb begin
    pcen_d = pcen_q;
    pdez_d = pdez_q;
    puni_d = puni_q;
    pvld_d = pvld_q;
    cen_d  = cen_q;
    dez_d  = dez_q;
    uni_d  = uni_q;
    if (frame_b) begin
      pvld_d = 1'b0;
      if (bcd.load) begin
        cen_d = bcd.centena;
        dez_d = bcd.dezena;
        uni_d = bcd.unidade;
      end else if (pvld_q) begin
        cen_d = pcen_q;
        dez_d = pdez_q;
        uni_d = puni_q;
      end
    end else if (bcd.load) begin
      pcen_d = bcd.centena;
      pdez_d = bcd.dezena;
      puni_d = bcd.unidade;
      pvld_d = 1'b1;
    end
    err_d = (cen_d > 4'd9) || (dez_d > 4'd9) || (uni_d > 4'd9);
  end

  always_comb begin
    cur_dig = uni_q;
    an_oh   = 3'b001;
    blank   = 1'b0;
    case (idx_q)
      SCAN_DEZ: begin
        cur_dig = dez_q;
        an_oh   = 3'b010;
      end
      SCAN_CEN: begin
        cur_dig = cen_q;
        an_oh   = 3'b100;
      end
      default: ;
    endcase
`ifdef SEG7_BLANK_LZ_EN
    if (idx_q == SCAN_CEN && cen_q == 4'd0)
      blank = 1'b1;
    if (idx_q == SCAN_DEZ && cen_q == 4'd0 && dez_q == 4'd0)
      blank = 1'b1;
`endif
    lit  = blank ? 7'b0000000 : dec7(cur_dig);
    seg_d = SEG_ACTIVE_LOW ? ~lit : lit;
    an_d  = AN_ACTIVE_LOW ? ~an_oh : an_oh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      idx_q  <= SCAN_UNI;
      pcen_q <= '0;
      pdez_q <= '0;
      puni_q <= '0;
      pvld_q <= 1'b0;
      cen_q  <= '0;
      dez_q  <= '0;
      uni_q  <= '0;
      err_q  <= 1'b0;
      seg_q  <= SEG_OFF;
      an_q   <= AN_OFF;
    end else begin
      div_q  <= div_d;
      idx_q  <= idx_d;
      pcen_q <= pcen_d;
      pdez_q <= pdez_d;
      puni_q <= puni_d;
      pvld_q <= pvld_d;
      cen_q  <= cen_d;
      dez_q  <= dez_d;
      uni_q  <= uni_d;
      err_q  <= err_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign frame = frame_b;
  assign err   = err_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Randomized bench for seg7_scan (DIV_WIDTH=2, active-low seg/an) against a slot/frame-count model.
module tb_seg7_scan;
  logic       clk;
  logic       rst_n;
  logic [6:0] seg;
  logic [2:0] an;
  logic       frame;
  logic       err;

  seg7_scan_if bus ();

  seg7_scan #(.DIV_WIDTH(2), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bcd   (bus),
    .seg   (seg),
    .an    (an),
    .frame (frame),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cnt;
  logic [3:0] m_dig [3];
  logic [3:0] m_pend [3];
  logic       m_pvld;
  logic       m_err;
  logic [6:0] exp_seg;
  logic [2:0] exp_an;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Segment set built from the letter list of each digit.
  function automatic logic [6:0] lit_of(input logic [3:0] v);
    string s;
    logic [6:0] r;
    case (v)
      4'd0: s = "abcdef";
      4'd1: s = "bc";
      4'd2: s = "abdeg";
      4'd3: s = "abcdg";
      4'd4: s = "bcfg";
      4'd5: s = "acdfg";
      4'd6: s = "acdefg";
      4'd7: s = "abc";
      4'd8: s = "abcdefg";
      4'd9: s = "abcdfg";
      default: s = "g";
    endcase
    r = '0;
    for (int i = 0; i < s.len(); i++) r[s[i] - 8'd97] = 1'b1;
    return r;
  endfunction

  function automatic logic [6:0] shown(input int slot);
    logic [6:0] r;
    r = lit_of(m_dig[slot]);
`ifdef SEG7_BLANK_LZ_EN
    if (slot == 2 && m_dig[2] == 4'd0) r = '0;
    if (slot == 1 && m_dig[2] == 4'd0 && m_dig[1] == 4'd0) r = '0;
`endif
    return r;
  endfunction

  task automatic model_clear();
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      m_dig[i]  = '0;
      m_pend[i] = '0;
    end
    m_pvld  = 1'b0;
    m_err   = 1'b0;
    exp_seg = 7'h7F;
    exp_an  = 3'h7;
  endtask

  // Called at a negedge: check, drive, predict the next posedge, move to next negedge.
  task automatic cycle(input logic ld, input logic [3:0] c, input logic [3:0] d, input logic [3:0] u);
    int  slot;
    logic frm;
    frm = ((cnt % 12) == 11);
    chk("frame", {31'd0, frame}, {31'd0, frm});
    chk("seg", {25'd0, seg}, {25'd0, exp_seg});
    chk("an", {29'd0, an}, {29'd0, exp_an});
    chk("err", {31'd0, err}, {31'd0, m_err});
    bus.load    = ld;
    bus.centena = c;
    bus.dezena  = d;
    bus.unidade = u;
    slot    = (cnt / 4) % 3;
    exp_an  = ~(3'b001 << slot);
    exp_seg = ~shown(slot);
    if (frm) begin
      if (ld) begin
        m_dig[2] = c; m_dig[1] = d; m_dig[0] = u;
      end else if (m_pvld) begin
        m_dig = m_pend;
      end
      m_pvld = 1'b0;
      m_err  = (m_dig[0] > 9) || (m_dig[1] > 9) || (m_dig[2] > 9);
    end else if (ld) begin
      m_pend[2] = c; m_pend[1] = d; m_pend[0] = u;
      m_pvld = 1'b1;
    end
    cnt++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 4'd0, 4'd0);
  endtask

  task automatic to_frame();
    while ((cnt % 12) != 11) cycle(1'b0, 4'd0, 4'd0, 4'd0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    bus.load = 1'b0;
    #1;
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_an", {29'd0, an}, 32'h7);
    chk("rst_frame", {31'd0, frame}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.load    = 1'b0;
    bus.centena = '0;
    bus.dezena  = '0;
    bus.unidade = '0;
    model_clear();
    @(negedge clk);
    do_reset();

    idle(40);
    idle(5);
    cycle(1'b1, 4'd2, 4'd5, 4'd5);
    idle(30);
    to_frame();
    cycle(1'b1, 4'd1, 4'd2, 4'd8);
    idle(30);
    cycle(1'b1, 4'd0, 4'd12, 4'd3);
    idle(30);
    cycle(1'b1, 4'd0, 4'd0, 4'd3);
    idle(30);
    cycle(1'b1, 4'd0, 4'd0, 4'd7);
    idle(30);
    to_frame();
    idle(2);
    cycle(1'b1, 4'd9, 4'd9, 4'd9);
    idle(3);
    do_reset();
    idle(30);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        logic       ld;
        logic [3:0] c, d, u;
        ld = ($urandom_range(0, 5) == 0);
        c  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        d  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        u  = 4'($urandom_range(0, 15));
        cycle(ld, c, d, u);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter DIV_WIDTH, default 16: width of the refresh divider; one digit slot lasts 2^DIV_WIDTH clocks.
REQ-002 Parameter SEG_ACTIVE_LOW, default 1: 1 means a lit segment drives 0 (common anode); 0 means a lit segment drives 1.
REQ-003 Parameter AN_ACTIVE_LOW, default 1: 1 means an enabled digit drives 0; 0 means an enabled digit drives 1.
REQ-004 Port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port load, input, 1 bit: strobe that captures the three BCD inputs.
REQ-007 Port centena, input, 4 bits: hundreds digit from the binary-to-BCD stage.
REQ-008 Port dezena, input, 4 bits: tens digit.
REQ-009 Port unidade, input, 4 bits: units digit.
REQ-010 Port seg, output, 7 bits: segment drive, with seg[0]=a through seg[6]=g.
REQ-011 Port an, output, 3 bits: digit enable, with an[0]=units, an[1]=tens, an[2]=hundreds.
REQ-012 Port frame, output, 1 bit: one-clock pulse at each frame boundary.
REQ-013 Port err, output, 1 bit: high while any committed digit is greater than 9.

Function
REQ-014 A DIV_WIDTH-bit divider shall increment every clock, wrap from all-ones to 0, and assert an internal tick in the all-ones cycle.
REQ-015 A 2-bit scan index shall advance 0->1->2->0 on each tick; index 3 is illegal and shall return to 0 on the next clock.
REQ-016 When load=1, a pending register set shall capture centena/dezena/unidade and set a pending flag.
REQ-017 A later load before commit shall overwrite the pending values, with no queueing.
REQ-018 Frame boundary: a tick while the index is 2 shall pulse frame high for exactly that clock.
REQ-019 At a frame boundary with the pending flag set, the pending values shall be copied into the display registers and the flag cleared.
REQ-020 Display registers shall never change at any other time, so a frame never mixes old and new digits.
REQ-021 If load and a frame boundary fall in the same clock, the values on the inputs that clock shall be committed directly (bypass) and the flag shall be left clear.
REQ-022 Digit decode for 0-9 shall use the standard patterns: 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=all, 9=abcdfg.
REQ-023 Digit values 10-15 shall display a dash (segment g only).
REQ-024 seg and an shall be registered, updating 1 clock after the scan index changes.
REQ-025 Exactly one bit of an shall be active at a time, except during reset.
REQ-026 err shall update at commit and be high if any committed digit is greater than 9.
REQ-027 Polarity shall be applied last: when the matching parameter is 1, a lit segment or enabled digit drives 0.

Reset
REQ-028 While rst_n=0, regardless of clk, the block shall clear the divider, scan index, pending registers, pending flag and display registers to 0.
REQ-029 While rst_n=0, seg shall be all off, an all off, and frame=0 and err=0.
REQ-030 On the first clock after rst_n rises, an[0] shall become active and seg shall show "0", unless blanking per REQ-033 applies.
REQ-031 Reset asserted mid-frame shall discard pending data; no commit shall occur afterwards until a new load.

Configuration
REQ-032 Macro SEG7_BLANK_LZ_EN shall compile leading-zero blanking in or out.
REQ-033 With SEG7_BLANK_LZ_EN defined, the hundreds digit shall be blanked (seg all off, an still asserted) when the committed hundreds = 0.
REQ-034 With SEG7_BLANK_LZ_EN defined, the tens digit shall be blanked when committed hundreds = 0 and tens = 0; units are never blanked.
REQ-035 With SEG7_BLANK_LZ_EN undefined, all three digits shall always be decoded and shown.

Verification (DIV_WIDTH=2, SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=1)
REQ-036 Reset scan: release rst_n -> an cycles 110, 101, 011 with 4 clocks per digit; frame pulses every 12 clocks; seg=1000000 ("0") on every digit when the macro is undefined.
REQ-037 Commit timing: load 2/5/5 mid-frame -> no display change until the next frame pulse; the following frame shows hundreds 0100100, tens 0010010, units 0010010.
REQ-038 Collision: load 1/2/8 in the frame-pulse clock -> the very next frame shows 1,2,8 and the pending flag is clear (no second commit).
REQ-039 Invalid digit: load 0/12/3 -> tens shows 0111111 (dash) and err=1 after commit; loading 0/0/3 clears err at the next commit.
REQ-040 Blanking with SEG7_BLANK_LZ_EN: load 0/0/7 -> hundreds and tens show seg=1111111 with their an bit still low; units show 1111000.
REQ-041 Reset mid-operation: load 9/9/9, assert rst_n=0 before the frame boundary, then release -> display shows 0/0/0 and no commit occurs.
